bat_program_loader: RTL and testbench
=====================================

# bat_program_loader

Boot and program-load controller for the BatAmateur CPU. It holds the CPU in reset and HALT, accepts a segmented program image over a valid/ready word stream, and writes the image into CPU memory through a tristate-able address/data/write-enable port. When the image's end marker arrives, it releases CPU reset and HALT in a fixed order. It replaces hand-written bus stimulus and sits between an external host link and the shared memory bus.

## Interface
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 16, memory word and stream word width.
- TIMEOUT_CYCLES, 1024, idle cycles allowed mid-load before abort; must be ≥2.
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  begin a load; honoured only in IDLE or RUN.
- LOAD_VALID  in  1  LOAD_WORD is valid.
- LOAD_WORD  in  DATA_WIDTH  stream word: header, count, or data.
- LOAD_READY  out  1  loader accepts LOAD_WORD this cycle.
- MEM_WE  out  1  one-cycle write strobe.
- MEM_ADDR  out  ADDR_WIDTH  write address.
- MEM_DATA  out  DATA_WIDTH  write data.
- BUS_EN  out  1  loader owns the memory bus; top level tristates MEM_ADDR/MEM_DATA when low.
- CPU_RESET  out  1  active-high CPU reset.
- HALT  out  1  CPU halt.
- BUSY  out  1  load in progress.
- ERROR  out  1  sticky timeout flag.

## Operation
- States: IDLE, ADDR, COUNT, DATA, RELEASE, RUN.
- A transfer occurs on a cycle with LOAD_VALID & LOAD_READY.
- LOAD_READY = 1 in ADDR, COUNT, and DATA only.
- IDLE: START → ADDR; ERROR cleared.
- ADDR: the transferred word is the segment base address; it is loaded into the address pointer → COUNT.
- COUNT: the transferred word is N.
  - N = 0 is the end marker → RELEASE.
  - N > 0: remaining counter = N → DATA.
- DATA: each transfer issues a write of the word at the pointer. The pointer then increments modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000), and remaining decrements. When remaining reaches 0, → ADDR for the next segment.
- RELEASE: one cycle → RUN.
- RUN: START → ADDR (reload): HALT and CPU_RESET reassert, ERROR cleared.
- START in ADDR/COUNT/DATA/RELEASE is ignored.
- Timeout: an idle counter runs in ADDR/COUNT/DATA on cycles with no transfer and clears on every transfer. On reaching TIMEOUT_CYCLES:
  - next state IDLE;
  - ERROR=1;
  - HALT and CPU_RESET stay asserted;
  - a partial segment is not rolled back.
- Output decode:
  - BUSY = state ∈ {ADDR, COUNT, DATA, RELEASE}.
  - BUS_EN = BUSY, or MEM_WE = 1.
  - CPU_RESET = 1 in all states except RELEASE and RUN.
  - HALT = 1 in all states except RUN.
- Widths: the count is DATA_WIDTH bits, so a segment may hold up to 65535 words. The pointer is ADDR_WIDTH bits with no overflow detection.

## Timing
- Reset values (async on RESET_N low):
  - state IDLE;
  - HALT=1, CPU_RESET=1;
  - MEM_WE=0, BUS_EN=0, BUSY=0, LOAD_READY=0, ERROR=0;
  - MEM_ADDR=0, MEM_DATA=0.
- Reset mid-load returns to these values immediately; memory writes already issued persist.
- Write latency: a transfer in DATA at cycle t gives MEM_WE=1 at t+1, with MEM_ADDR/MEM_DATA registered from the transfer. MEM_WE is a single cycle per word.
- Back-to-back transfers produce back-to-back writes at consecutive addresses.
- The last-word write at t+1 overlaps ADDR (next segment) or the timeout abort. BUS_EN stays 1 through that write cycle.
- End marker accepted at cycle t: t+1 is RELEASE (CPU_RESET=0, HALT=1); t+2 is RUN (HALT=0, BUS_EN=0).
- START is sampled at cycle t: LOAD_READY=1 at t+1. From RUN, HALT=1 and CPU_RESET=1 at t+1.
- Timeout: ERROR rises on the cycle after the TIMEOUT_CYCLES-th consecutive idle cycle.

## Test plan
- Reset: hold RESET_N=0 with toggling inputs → HALT=1, CPU_RESET=1, all other outputs 0. Assert RESET_N=0 asynchronously mid-DATA → outputs return to reset values before the next edge.
- Basic load: START, then stream 0x0010, 3, 0x0000, 0x0001, 0x0005, then 0x0000 (header), 13, and words 0x0012, 0x7F98, 0x0010, 0x0011, 0x7041, 0x7F91, 0x7F88, 0x7F82, 0x7FBA, 0x73E1, 0x6FF9, 0xF000, 0x4FFF, then header 0x0000 and count 0 → exactly 16 MEM_WE pulses at 0x0010–0x0012 and 0x0000–0x000C with matching data. CPU_RESET falls 1 cycle and HALT falls 2 cycles after the final count is accepted.
- Wrap-around: header 0xFFFE, count 4 → writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Backpressure/gaps: random LOAD_VALID gaps shorter than TIMEOUT_CYCLES → write sequence identical to the gap-free case. No MEM_WE on cycles without a transfer.
- Timeout: stop the stream after 2 of 5 data words with TIMEOUT_CYCLES=16 → 2 writes, ERROR=1 after 16 idle cycles, state IDLE, HALT=1. A following START clears ERROR.
- Reload from RUN: START in RUN → HALT=1 and CPU_RESET=1 next cycle. START pulses during DATA are ignored (the count sequence is unaffected).

Source files
------------

// File: rtl/bat_program_loader.sv
// bat_program_loader
//
// Boot and program-load controller for the BatAmateur CPU. Holds the CPU in
// reset and HALT and accepts a segmented image over a valid/ready stream.
// Each segment is a base-address word, a count word N, then N data words.
// N = 0 marks the end of the image. The image is written into CPU memory, and
// then CPU_RESET and HALT are released in a fixed order (reset first, then halt).
//
// Ports
//   CLK         rising-edge clock
//   RESET_N     asynchronous active-low reset
//   START       begin a load (honoured in IDLE or RUN only)
//   LOAD_VALID  LOAD_WORD is valid
//   LOAD_WORD   stream word: header, count, or data
//   LOAD_READY  loader accepts LOAD_WORD this cycle
//   MEM_WE      one-cycle memory write strobe
//   MEM_ADDR    memory write address
//   MEM_DATA    memory write data
//   BUS_EN      loader owns the memory bus (the top level tristates when low)
//   CPU_RESET   active-high CPU reset
//   HALT        CPU halt
//   BUSY        load in progress
//   ERROR       sticky timeout flag, cleared by an accepted START
module bat_program_loader #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  LOAD_VALID,
    input  logic [DATA_WIDTH-1:0] LOAD_WORD,
    output logic                  LOAD_READY,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_DATA,
    output logic                  BUS_EN,
    output logic                  CPU_RESET,
    output logic                  HALT,
    output logic                  BUSY,
    output logic                  ERROR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic                    loading;
    logic                    xfer;
    logic                    timeout;
    logic                    start_ok;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   remaining;
    logic [IDLE_W-1:0]       idle_cnt;

    assign loading  = state inside {S_ADDR, S_COUNT, S_DATA};
    assign xfer     = LOAD_VALID && loading;
    // The counter holds TIMEOUT_CYCLES-1 during the last allowed idle cycle.
    // A further idle cycle at that point aborts the load.
    assign timeout  = loading && !xfer && (idle_cnt == IDLE_LAST);
    assign start_ok = START && ((state == S_IDLE) || (state == S_RUN));

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RUN: begin
                if (START) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (xfer) state_next = S_COUNT;
            end
            S_COUNT: begin
                if (xfer) state_next = (LOAD_WORD == '0) ? S_RELEASE : S_DATA;
            end
            S_DATA: begin
                if (xfer && (remaining == DATA_WIDTH'(1))) state_next = S_ADDR;
            end
            S_RELEASE: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // An abort wins over any other transition. A partially written segment
        // is left in memory as it is.
        if (timeout) state_next = S_IDLE;
    end

    // Address pointer, segment counter, idle counter, write port, error flag
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr       <= '0;
            remaining <= '0;
            idle_cnt  <= '0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_DATA  <= '0;
            ERROR     <= 1'b0;
        end else begin
            MEM_WE <= 1'b0;

            if ((state == S_ADDR) && xfer) begin
                ptr <= ADDR_WIDTH'(LOAD_WORD);
            end

            if ((state == S_COUNT) && xfer) begin
                remaining <= LOAD_WORD;
            end

            // Each accepted data word becomes a write on the following cycle.
            // The pointer wraps silently at the top of the address space.
            if ((state == S_DATA) && xfer) begin
                MEM_WE    <= 1'b1;
                MEM_ADDR  <= ptr;
                MEM_DATA  <= LOAD_WORD;
                ptr       <= ptr + ADDR_WIDTH'(1);
                remaining <= remaining - DATA_WIDTH'(1);
            end

            if (loading && !xfer && !timeout) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (start_ok) begin
                ERROR <= 1'b0;
            end else if (timeout) begin
                ERROR <= 1'b1;
            end
        end
    end

    // Output decode
    always_comb begin
        LOAD_READY = loading;
        BUSY       = loading || (state == S_RELEASE);
        // The final write of a segment can land after the FSM has left DATA.
        // Ownership of the bus is therefore held through that write.
        BUS_EN     = BUSY || MEM_WE;
        CPU_RESET  = !((state == S_RELEASE) || (state == S_RUN));
        HALT       = (state != S_RUN);
    end

endmodule

// File: tb/tb_bat_program_loader.sv
// tb_bat_program_loader
//
// Directed bench for bat_program_loader. A negedge monitor collects every
// MEM_WE pulse into a write log. The log is compared against hand-listed
// expected address/data sequences. The monitor also flags any write that does
// not follow an accepted stream transfer.
module tb_bat_program_loader;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 16;

    localparam logic [15:0] BASIC_STREAM [22] = '{
        16'h0010, 16'h0003, 16'h0000, 16'h0001, 16'h0005,
        16'h0000, 16'h000D,
        16'h0012, 16'h7F98, 16'h0010, 16'h0011, 16'h7041, 16'h7F91, 16'h7F88,
        16'h7F82, 16'h7FBA, 16'h73E1, 16'h6FF9, 16'hF000, 16'h4FFF,
        16'h0000, 16'h0000
    };
    localparam logic [15:0] BASIC_ADDR [16] = '{
        16'h0010, 16'h0011, 16'h0012,
        16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006,
        16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h000B, 16'h000C
    };
    localparam logic [15:0] BASIC_DATA [16] = '{
        16'h0000, 16'h0001, 16'h0005,
        16'h0012, 16'h7F98, 16'h0010, 16'h0011, 16'h7041, 16'h7F91, 16'h7F88,
        16'h7F82, 16'h7FBA, 16'h73E1, 16'h6FF9, 16'hF000, 16'h4FFF
    };

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START = 1'b0;
    logic          LOAD_VALID = 1'b0;
    logic [DW-1:0] LOAD_WORD = '0;
    logic          LOAD_READY;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic          BUS_EN;
    logic          CPU_RESET;
    logic          HALT;
    logic          BUSY;
    logic          ERROR;

    int n_tests = 0;
    int n_fail  = 0;
    int spurious = 0;
    logic prev_xfer = 1'b0;

    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];
    logic [AW-1:0] ex_addr [$];
    logic [DW-1:0] ex_data [$];

    bat_program_loader #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .LOAD_VALID(LOAD_VALID),
        .LOAD_WORD (LOAD_WORD),
        .LOAD_READY(LOAD_READY),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DATA  (MEM_DATA),
        .BUS_EN    (BUS_EN),
        .CPU_RESET (CPU_RESET),
        .HALT      (HALT),
        .BUSY      (BUSY),
        .ERROR     (ERROR)
    );

    always #5 CLK = ~CLK;

    // Write monitor: a write is legitimate only if the previous cycle had a transfer.
    always @(negedge CLK) begin
        if (MEM_WE) begin
            wr_addr.push_back(MEM_ADDR);
            wr_data.push_back(MEM_DATA);
            if (!prev_xfer) spurious <= spurious + 1;
        end
        prev_xfer <= LOAD_VALID && LOAD_READY;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Optional idle gap (with START noise) then hold LOAD_VALID until accepted.
    task automatic send(input logic [DW-1:0] w, input int gap, input bit noise);
        bit done;
        done = 1'b0;
        for (int g = 0; g < gap; g++) begin
            START = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        START      = 1'b0;
        LOAD_VALID = 1'b1;
        LOAD_WORD  = w;
        for (int k = 0; k < 64 && !done; k++) begin
            done = LOAD_READY;
            tick();
        end
        LOAD_VALID = 1'b0;
        if (!done) check("send_stall", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        ex_addr.delete();
        ex_data.delete();
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ex_addr.push_back(a);
        ex_data.push_back(d);
    endtask

    task automatic compare_writes(input string tag);
        check($sformatf("%s_nwrites", tag), wr_addr.size(), ex_addr.size());
        for (int i = 0; i < ex_addr.size() && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], ex_addr[i]);
            check($sformatf("%s_data%0d", tag, i), wr_data[i], ex_data[i]);
        end
        check($sformatf("%s_spurious_we", tag), spurious, 0);
    endtask

    // Stream the basic two-segment image and check the release sequence.
    task automatic run_image(input string tag, input bit noise);
        for (int i = 0; i < 21; i++) begin
            send(BASIC_STREAM[i], noise ? int'($urandom_range(0, 10)) : 0, noise);
        end
        check({tag, "_rst_before_end"}, CPU_RESET, 1);
        send(BASIC_STREAM[21], 0, 1'b0);
        check({tag, "_release_rst"}, CPU_RESET, 0);
        check({tag, "_release_halt"}, HALT, 1);
        check({tag, "_release_busen"}, BUS_EN, 1);
        tick();
        check({tag, "_run_halt"}, HALT, 0);
        check({tag, "_run_rst"}, CPU_RESET, 0);
        check({tag, "_run_busen"}, BUS_EN, 0);
        check({tag, "_run_busy"}, BUSY, 0);
    endtask

    initial begin
        // Reset held with toggling inputs
        for (int i = 0; i < 6; i++) begin
            START      = 1'(i % 2);
            LOAD_VALID = 1'((i / 2) % 2);
            LOAD_WORD  = DW'($urandom);
            tick();
        end
        check("rst_halt", HALT, 1);
        check("rst_cpu_reset", CPU_RESET, 1);
        check("rst_mem_we", MEM_WE, 0);
        check("rst_bus_en", BUS_EN, 0);
        check("rst_busy", BUSY, 0);
        check("rst_ready", LOAD_READY, 0);
        check("rst_error", ERROR, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_data", MEM_DATA, 0);
        START      = 1'b0;
        LOAD_VALID = 1'b0;
        LOAD_WORD  = '0;
        RESET_N    = 1'b1;
        tick();
        check("idle_busy", BUSY, 0);
        check("idle_ready", LOAD_READY, 0);

        // Basic load, no gaps
        clear_log();
        for (int i = 0; i < 16; i++) expect_write(BASIC_ADDR[i], BASIC_DATA[i]);
        pulse_start();
        check("start_ready", LOAD_READY, 1);
        check("start_busy", BUSY, 1);
        check("start_busen", BUS_EN, 1);
        run_image("basic", 1'b0);
        compare_writes("basic");

        // Reload from RUN, wrap-around segment
        clear_log();
        expect_write(16'hFFFE, 16'hA001);
        expect_write(16'hFFFF, 16'hA002);
        expect_write(16'h0000, 16'hA003);
        expect_write(16'h0001, 16'hA004);
        pulse_start();
        check("reload_halt", HALT, 1);
        check("reload_rst", CPU_RESET, 1);
        check("reload_ready", LOAD_READY, 1);
        send(16'hFFFE, 0, 1'b0);
        send(16'h0004, 0, 1'b0);
        send(16'hA001, 0, 1'b0);
        send(16'hA002, 0, 1'b0);
        send(16'hA003, 0, 1'b0);
        send(16'hA004, 0, 1'b0);
        send(16'h0000, 0, 1'b0);
        send(16'h0000, 0, 1'b0);
        tick();
        check("wrap_run_halt", HALT, 0);
        compare_writes("wrap");

        // Random gaps with START noise: same write sequence as the basic load
        clear_log();
        for (int i = 0; i < 16; i++) expect_write(BASIC_ADDR[i], BASIC_DATA[i]);
        pulse_start();
        run_image("gaps", 1'b1);
        compare_writes("gaps");

        // Timeout after 2 of 5 data words
        clear_log();
        expect_write(16'h0100, 16'h1111);
        expect_write(16'h0101, 16'h2222);
        pulse_start();
        send(16'h0100, 0, 1'b0);
        send(16'h0005, 0, 1'b0);
        send(16'h1111, 0, 1'b0);
        send(16'h2222, 0, 1'b0);
        repeat (TO - 1) tick();
        check("to_error_early", ERROR, 0);
        check("to_busy_early", BUSY, 1);
        tick();
        check("to_error", ERROR, 1);
        check("to_busy", BUSY, 0);
        check("to_ready", LOAD_READY, 0);
        check("to_halt", HALT, 1);
        check("to_rst", CPU_RESET, 1);
        repeat (3) tick();
        check("to_error_sticky", ERROR, 1);
        check("to_still_idle", BUSY, 0);
        compare_writes("timeout");
        pulse_start();
        check("to_restart_error", ERROR, 0);
        check("to_restart_ready", LOAD_READY, 1);
        send(16'h0000, 0, 1'b0);
        send(16'h0000, 0, 1'b0);
        tick();
        check("to_restart_run", HALT, 0);

        // Asynchronous reset in the middle of DATA
        pulse_start();
        send(16'h0200, 0, 1'b0);
        send(16'h0003, 0, 1'b0);
        send(16'hABCD, 0, 1'b0);
        check("ar_we_before", MEM_WE, 1);
        check("ar_addr_before", MEM_ADDR, 16'h0200);
        #2;
        RESET_N = 1'b0;
        #1;
        check("ar_halt", HALT, 1);
        check("ar_rst", CPU_RESET, 1);
        check("ar_we", MEM_WE, 0);
        check("ar_busen", BUS_EN, 0);
        check("ar_busy", BUSY, 0);
        check("ar_ready", LOAD_READY, 0);
        check("ar_error", ERROR, 0);
        check("ar_addr", MEM_ADDR, 0);
        check("ar_data", MEM_DATA, 0);
        tick();
        RESET_N = 1'b1;
        tick();
        check("ar_idle_busy", BUSY, 0);
        check("ar_spurious_we", spurious, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
